apb_rr_arbiter: RTL and testbench

Two-master round-robin arbiter that shares one downstream APB target bus between the AXI4-Lite→APB bridge (master 0) and a second APB master (master 1, e.g. debug/config sequencer). It grants one master per transfer, drives the shared bus from a latched copy of that master's request, and returns PREADY/PRDATA/PSLVERR only to the granted master. A programmable access timeout terminates hung transfers with an error.

---
 rtl/apb_arb_pkg.sv | 19 +
 rtl/apb_arb_timeout.sv | 53 +++++
 rtl/apb_rr_arbiter.sv | 159 +++++++++++++++
 tb/tb_apb_rr_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the two-master APB round-robin arbiter.
package apb_arb_pkg;

  // Shared-bus phase of the arbiter.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_e;

  localparam int unsigned NUM_MASTERS = 2;

  // Width of the access-timeout counter; one bit minimum so a disabled
  // timeout (0) still yields a legal vector width.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_arb_timeout.sv
// Access-phase watchdog: counts ACCESS cycles without PREADY and flags the
// cycle in which the TIMEOUT-th such cycle occurs. TIMEOUT = 0 disables it.
module apb_arb_timeout
  import apb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,      // clear (held during SETUP)
  input  logic en_i,       // ACCESS cycle with PREADY low
  output logic expired_o   // this waiting cycle is the TIMEOUT-th one
);

  localparam int unsigned CW = cnt_width(TIMEOUT);

  generate
    if (TIMEOUT == 0) begin : g_disabled
      logic unused_tmo;
      assign unused_tmo = ^{clk, rst_n, clr_i, en_i};
      assign expired_o  = 1'b0;
    end else begin : g_enabled
      localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

      logic [CW-1:0] cnt_q, cnt_d;

      // Next count: clear wins, otherwise count waiting cycles and saturate.
      always_comb begin
        // NOTE: assign a default before any branch so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr_i) begin
          cnt_d = '0;
        end else if (en_i && (cnt_q != LAST_CNT)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Counter register.
      always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking (<=) in clocked blocks so every flop samples pre-edge values.
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // cnt_q counts earlier waiting cycles, so LAST_CNT marks the TIMEOUT-th.
      assign expired_o = en_i && (cnt_q == LAST_CNT);
    end
  endgenerate

endmodule

// File: rtl/apb_rr_arbiter.sv
// Two-master round-robin arbiter sharing one APB target bus. The winner's
// request is latched at grant; responses are routed only to the granted master.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  // master 0
  input  logic                    M0_PSEL,
  input  logic                    M0_PENABLE,
  input  logic                    M0_PWRITE,
  input  logic [ADDR_WIDTH-1:0]   M0_PADDR,
  input  logic [DATA_WIDTH-1:0]   M0_PWDATA,
  input  logic [DATA_WIDTH/8-1:0] M0_PWSTRB,
  output logic                    M0_PREADY,
  output logic [DATA_WIDTH-1:0]   M0_PRDATA,
  output logic                    M0_PSLVERR,
  // master 1
  input  logic                    M1_PSEL,
  input  logic                    M1_PENABLE,
  input  logic                    M1_PWRITE,
  input  logic [ADDR_WIDTH-1:0]   M1_PADDR,
  input  logic [DATA_WIDTH-1:0]   M1_PWDATA,
  input  logic [DATA_WIDTH/8-1:0] M1_PWSTRB,
  output logic                    M1_PREADY,
  output logic [DATA_WIDTH-1:0]   M1_PRDATA,
  output logic                    M1_PSLVERR,
  // shared target bus
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PWSTRB,
  input  logic                    PREADY,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PSLVERR,
  output logic                    GNT
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef struct packed {
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [STRB_WIDTH-1:0] pwstrb;
  } apb_req_t;

  arb_state_e            state_q, state_d;
  apb_req_t              req_q, req_d;
  apb_req_t              m0_req, m1_req;
  logic                  gnt_q, gnt_d;
  logic                  last_q, last_d;
  logic                  winner;
  logic [1:0]            req_vec;
  logic                  done;        // target completed this ACCESS cycle
  logic                  tmo_done;    // watchdog forced completion
  logic                  complete;
  logic                  expired;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  // Master-side PENABLE carries no information the arbiter needs.
  logic unused_penable;
  assign unused_penable = M0_PENABLE ^ M1_PENABLE;

  assign m0_req  = '{pwrite: M0_PWRITE, paddr: M0_PADDR, pwdata: M0_PWDATA, pwstrb: M0_PWSTRB};
  assign m1_req  = '{pwrite: M1_PWRITE, paddr: M1_PADDR, pwdata: M1_PWDATA, pwstrb: M1_PWSTRB};
  assign req_vec = {M1_PSEL, M0_PSEL};

  // A target PREADY wins over a coinciding timeout.
  assign done     = (state_q == ACCESS) && PREADY;
  assign tmo_done = (state_q == ACCESS) && expired;
  assign complete = done || tmo_done;

  apb_arb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (ACLK),
    .rst_n     (ARESET),
    .clr_i     (state_q == SETUP),
    .en_i      ((state_q == ACCESS) && !PREADY),
    .expired_o (expired)
  );

  // Next state: arbitrate in IDLE, walk SETUP -> ACCESS, release on completion.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    winner  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_vec != 2'b00) begin
          // On a tie the master not served last wins; otherwise the sole requester.
          winner  = (req_vec == 2'b11) ? ~last_q : req_vec[1];
          gnt_d   = winner;
          req_d   = winner ? m1_req : m0_req;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (complete) begin
          last_d  = gnt_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, grant, round-robin pointer and latched request registers.
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      state_q <= IDLE;
      req_q   <= '0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;   // master 0 wins the first tie
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // Shared bus: control from the phase, payload from the latched request.
  assign PSEL    = (state_q != IDLE);
  assign PENABLE = (state_q == ACCESS);
  assign PWRITE  = req_q.pwrite;
  assign PADDR   = req_q.paddr;
  assign PWDATA  = req_q.pwdata;
  assign PWSTRB  = req_q.pwstrb;
  assign GNT     = gnt_q;

  // Completion payload: target pass-through, or a zero-data error on timeout.
  assign rsp_rdata = done ? PRDATA : '0;
  assign rsp_err   = done ? PSLVERR : tmo_done;

  // Only the granted master ever sees a response; the other waits.
  assign M0_PREADY  = complete && !gnt_q;
  assign M0_PRDATA  = gnt_q ? '0 : rsp_rdata;
  assign M0_PSLVERR = !gnt_q && rsp_err;
  assign M1_PREADY  = complete && gnt_q;
  assign M1_PRDATA  = gnt_q ? rsp_rdata : '0;
  assign M1_PSLVERR = gnt_q && rsp_err;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Self-checking bench for apb_rr_arbiter: two master drivers, a target model
// and a scoreboard of expected completions in grant order.
module tb_apb_rr_arbiter;

  localparam int TMO = 4;

  typedef struct {
    int          mst;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;      // what the target returns
    bit          slverr;     // what the target returns
    int          waits;      // ACCESS wait cycles before target PREADY
    bit          hang;       // target never answers
    logic [31:0] exp_rdata;
    bit          exp_err;
  } xfer_t;

  logic        clk = 1'b0;
  logic        ARESET = 1'b0;

  logic [1:0]  m_psel    = '0;
  logic [1:0]  m_penable = '0;
  logic [1:0]  m_pwrite  = '0;
  logic [31:0] m_paddr  [2] = '{default: '0};
  logic [31:0] m_pwdata [2] = '{default: '0};
  logic [3:0]  m_pwstrb [2] = '{default: '0};
  logic [1:0]  m_pready;
  logic [1:0]  m_pslverr;
  logic [31:0] m0_prdata, m1_prdata;

  logic        psel, penable, pwrite, gnt;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pwstrb;
  logic        pready  = 1'b0;
  logic [31:0] prdata  = '0;
  logic        pslverr = 1'b0;

  xfer_t       sb[$];
  xfer_t       jq0[$], jq1[$];
  logic [1:0]  m_busy    = '0;
  int          t_acc     = 0;
  bit          tgt_pulse = 1'b0;
  bit          exp_idle  = 1'b0;
  int          n_checks  = 0;
  int          n_errors  = 0;

  always #5 clk = ~clk;

  apb_rr_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .TIMEOUT    (TMO)
  ) dut (
    .ACLK       (clk),
    .ARESET     (ARESET),
    .M0_PSEL    (m_psel[0]),
    .M0_PENABLE (m_penable[0]),
    .M0_PWRITE  (m_pwrite[0]),
    .M0_PADDR   (m_paddr[0]),
    .M0_PWDATA  (m_pwdata[0]),
    .M0_PWSTRB  (m_pwstrb[0]),
    .M0_PREADY  (m_pready[0]),
    .M0_PRDATA  (m0_prdata),
    .M0_PSLVERR (m_pslverr[0]),
    .M1_PSEL    (m_psel[1]),
    .M1_PENABLE (m_penable[1]),
    .M1_PWRITE  (m_pwrite[1]),
    .M1_PADDR   (m_paddr[1]),
    .M1_PWDATA  (m_pwdata[1]),
    .M1_PWSTRB  (m_pwstrb[1]),
    .M1_PREADY  (m_pready[1]),
    .M1_PRDATA  (m1_prdata),
    .M1_PSLVERR (m_pslverr[1]),
    .PSEL       (psel),
    .PENABLE    (penable),
    .PWRITE     (pwrite),
    .PADDR      (paddr),
    .PWDATA     (pwdata),
    .PWSTRB     (pwstrb),
    .PREADY     (pready),
    .PRDATA     (prdata),
    .PSLVERR    (pslverr),
    .GNT        (gnt)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Queue one transfer: job for its master plus the expected completion.
  task automatic add_xfer(input int mst, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [31:0] rdata, input bit slverr,
                          input int waits, input bit hang);
    xfer_t x;
    x.mst       = mst;
    x.wr        = wr;
    x.addr      = addr;
    x.wdata     = wdata;
    x.strb      = strb;
    x.rdata     = rdata;
    x.slverr    = slverr;
    x.waits     = waits;
    x.hang      = hang;
    x.exp_rdata = hang ? 32'h0 : rdata;
    x.exp_err   = hang ? 1'b1 : slverr;
    sb.push_back(x);
    if (mst == 0) jq0.push_back(x);
    else          jq1.push_back(x);
  endtask

  // Wait for all queued work to finish, bounded by a cycle budget.
  task automatic drain(input string tag, input int budget);
    int cyc = 0;
    bit ok;
    while ((sb.size() != 0 || jq0.size() != 0 || jq1.size() != 0 || m_busy != 2'b00)
           && cyc < budget) begin
      @(posedge clk);
      cyc++;
    end
    ok = (sb.size() == 0 && jq0.size() == 0 && jq1.size() == 0 && m_busy == 2'b00);
    check(tag, ok, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Per-cycle: target responds on the falling edge, monitor checks at +2,
  // master drivers update at +3.
  always @(negedge clk) begin : bench_loop
    xfer_t e;
    xfer_t j;

    // target model
    if (psel && penable && sb.size() != 0) begin
      t_acc++;
      if (!sb[0].hang && t_acc == sb[0].waits + 1) begin
        pready  = 1'b1;
        prdata  = sb[0].rdata;
        pslverr = sb[0].slverr;
      end else begin
        pready  = 1'b0;
        prdata  = 32'hDEAD_BEEF;
        pslverr = 1'b0;
      end
    end else begin
      pready  = tgt_pulse;
      prdata  = 32'h0;
      pslverr = 1'b0;
      t_acc   = 0;
    end

    #2;
    // monitor / scoreboard
    if (ARESET) begin
      if (exp_idle) begin
        check("idle_gap_psel", psel, 1'b0);
        exp_idle = 1'b0;
      end
      if (psel && sb.size() == 0) check("spurious_psel", psel, 1'b0);
      if (psel && sb.size() != 0) begin
        e = sb[0];
        check("bus_fields_stable", {pwrite, paddr, pwdata, pwstrb}, {e.wr, e.addr, e.wdata, e.strb});
        if (e.mst == 0) check("m1_quiet", {m_pready[1], m_pslverr[1], m1_prdata}, '0);
        else            check("m0_quiet", {m_pready[0], m_pslverr[0], m0_prdata}, '0);
      end
      if (m_pready != 2'b00) begin
        if (sb.size() == 0) begin
          check("unexpected_pready", m_pready, 2'b00);
        end else begin
          e = sb.pop_front();
          check("gnt", gnt, e.mst[0]);
          check("pready_dest", m_pready, (e.mst == 0) ? 2'b01 : 2'b10);
          check("prdata", (e.mst == 0) ? m0_prdata : m1_prdata, e.exp_rdata);
          check("pslverr", m_pslverr[e.mst], e.exp_err);
          check("access_cycles", t_acc, e.hang ? TMO : e.waits + 1);
          exp_idle = 1'b1;
        end
      end
    end

    #1;
    // master drivers
    for (int n = 0; n < 2; n++) begin
      if (m_busy[n] && m_pready[n]) begin
        if (n == 0) j = jq0.pop_front();
        else        j = jq1.pop_front();
        m_busy[n] = 1'b0;
      end
      if (!m_busy[n] && ((n == 0) ? jq0.size() : jq1.size()) != 0) begin
        if (n == 0) j = jq0[0];
        else        j = jq1[0];
        m_busy[n]    = 1'b1;
        m_psel[n]    = 1'b1;
        m_penable[n] = 1'b0;
        m_pwrite[n]  = j.wr;
        m_paddr[n]   = j.addr;
        m_pwdata[n]  = j.wdata;
        m_pwstrb[n]  = j.strb;
      end else if (!m_busy[n]) begin
        m_psel[n]    = 1'b0;
        m_penable[n] = 1'b0;
      end else if (penable && gnt == n[0]) begin
        // scramble master-side fields mid-access; the shared bus must not follow
        m_penable[n] = 1'b1;
        m_pwrite[n]  = ~m_pwrite[n];
        m_paddr[n]   = ~m_paddr[n];
        m_pwdata[n]  = ~m_pwdata[n];
        m_pwstrb[n]  = ~m_pwstrb[n];
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    // reset held with M0 requesting
    add_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'h11, 1'b0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_bus", {psel, penable, pwrite, paddr, pwdata, pwstrb, gnt}, '0);
    check("rst_rsp", {m_pready, m_pslverr, m0_prdata, m1_prdata}, '0);
    @(negedge clk);
    #4;
    ARESET = 1'b1;
    @(posedge clk);
    #1;
    check("rel_psel_penable", {psel, penable}, 2'b10);
    check("rel_paddr", paddr, 32'h10);
    check("rel_gnt", gnt, 1'b0);
    drain("drain_reset", 50);

    // single zero-wait write from M0
    add_xfer(0, 1'b1, 32'h30, 32'h38, 4'hF, 32'h0, 1'b0, 0, 1'b0);
    drain("drain_write", 50);

    // M1 write with 3 wait states and target error; stray PREADY in IDLE/SETUP
    tgt_pulse = 1'b1;
    add_xfer(1, 1'b1, 32'h54, 32'h1234_5678, 4'h3, 32'h5A, 1'b1, 3, 1'b0);
    drain("drain_wait_err", 50);
    tgt_pulse = 1'b0;

    // contention: pointer last served M1, so M0 goes first
    add_xfer(0, 1'b0, 32'h4C, 32'h0, 4'h0, 32'h46, 1'b0, 0, 1'b0);
    add_xfer(1, 1'b0, 32'h4D, 32'h0, 4'h0, 32'h4B, 1'b0, 0, 1'b0);
    drain("drain_contention", 50);

    // fairness: both hold PSEL for six transfers, grants alternate 0,1,0,1,0,1
    for (int i = 0; i < 3; i++) begin
      add_xfer(0, 1'b0, 32'h100 + 32'(i * 8), 32'h0, 4'h0, 32'hA0 + 32'(i), 1'b0, i % 2, 1'b0);
      add_xfer(1, 1'b1, 32'h180 + 32'(i * 8), 32'hC0DE_0000 + 32'(i), 4'h5, 32'hB0 + 32'(i), 1'b0, i, 1'b0);
    end
    drain("drain_fairness", 150);

    // timeout: target never answers, error completion in the TMO-th ACCESS cycle
    add_xfer(0, 1'b0, 32'h200, 32'h0, 4'h0, 32'h77, 1'b0, 0, 1'b1);
    drain("drain_timeout", 50);

    // late target PREADY after the forced completion is ignored
    tgt_pulse = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("late_pready_ignored", {m_pready, psel}, 3'b000);
    end
    tgt_pulse = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
